// File: rtl/cma_ext_seq.sv
// Job sequencer for the CMA array top: streams load words into the external port,
// arms the array, waits for completion (with timeout) and streams readback results.
module cma_ext_seq #(
    parameter int DATA_W  = 32,
    parameter int EXA_W   = 14,
    parameter int ROMUL_W = 2,
    parameter int TO_CYC  = 65535
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_bank_in,
    input  logic [EXA_W-1:0]   i_wr_base,
    input  logic [EXA_W-1:0]   i_rd_base,
    input  logic [EXA_W-1:0]   i_wr_cnt,
    input  logic [EXA_W-1:0]   i_rd_cnt,
    input  logic               i_src_valid,
    input  logic [ROMUL_W-1:0] i_src_romul,
    input  logic [DATA_W-1:0]  i_src_data,
    output logic               o_src_ready,
    output logic               o_exwe,
    output logic               o_exre,
    output logic [EXA_W-1:0]   o_exa,
    output logic [DATA_W-1:0]  o_exwd,
    output logic [ROMUL_W-1:0] o_exromul,
    input  logic [DATA_W-1:0]  i_exrd,
    output logic               o_cbank,
    output logic               o_run,
    input  logic               i_done,
    output logic               o_res_valid,
    output logic [DATA_W-1:0]  o_res_data,
    input  logic               i_res_ready,
    output logic               o_busy,
    output logic               o_err
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_ARM       = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RD_ISSUE  = 3'd4;
    localparam logic [2:0] S_RD_CAP    = 3'd5;
    localparam logic [2:0] S_RD_HOLD   = 3'd6;

    localparam int               TO_W      = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0]  L_TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [TO_W-1:0]  L_TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [EXA_W-1:0] L_A_ZERO  = {EXA_W{1'b0}};
    localparam logic [EXA_W-1:0] L_A_ONE   = {{(EXA_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [EXA_W-1:0]  r_wr_addr;
    logic [EXA_W-1:0]  r_wr_left;
    logic [EXA_W-1:0]  r_rd_addr;
    logic [EXA_W-1:0]  r_rd_left;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_run;
    logic              r_cbank;
    logic              r_err;
    logic [DATA_W-1:0] r_res_data;
    logic              w_wr_hs;
    logic              w_start_acc;
    logic              w_to_hit;

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_wr_hs     = (r_state == S_LOAD) && i_src_valid;
    assign w_to_hit    = (r_state == S_WAIT_DONE) && (r_to_cnt == L_TO_LAST);

    // Next-state selection; DONE takes priority over a timeout in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_wr_cnt != L_A_ZERO) ? S_LOAD : S_ARM;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_wr_hs && (r_wr_left == L_A_ONE)) begin
                    w_next_state = S_ARM;
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_ARM: begin
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_done) begin
                    w_next_state = (r_rd_left != L_A_ZERO) ? S_RD_ISSUE : S_IDLE;
                end else if (w_to_hit) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_RD_ISSUE: begin
                w_next_state = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_next_state = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                if (i_res_ready) begin
                    w_next_state = (r_rd_left == L_A_ONE) ? S_IDLE : S_RD_ISSUE;
                end else begin
                    w_next_state = S_RD_HOLD;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Job parameters and running address / remaining-word counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_addr <= L_A_ZERO;
            r_wr_left <= L_A_ZERO;
            r_rd_addr <= L_A_ZERO;
            r_rd_left <= L_A_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_wr_addr <= i_wr_base;
                        r_wr_left <= i_wr_cnt;
                        r_rd_addr <= i_rd_base;
                        r_rd_left <= i_rd_cnt;
                    end
                end
                S_LOAD: begin
                    if (i_src_valid) begin
                        r_wr_addr <= r_wr_addr + L_A_ONE;
                        r_wr_left <= r_wr_left - L_A_ONE;
                    end
                end
                S_RD_HOLD: begin
                    if (i_res_ready) begin
                        r_rd_addr <= r_rd_addr + L_A_ONE;
                        r_rd_left <= r_rd_left - L_A_ONE;
                    end
                end
                default: begin
                    r_wr_addr <= r_wr_addr;
                end
            endcase
        end
    end

    // Cycles spent in WAIT_DONE, restarted on every entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (r_state == S_WAIT_DONE) begin
            r_to_cnt <= r_to_cnt + L_TO_ONE;
        end else begin
            r_to_cnt <= {TO_W{1'b0}};
        end
    end

    // Array control: RUN follows WAIT_DONE, bank held for the whole job, sticky timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run   <= 1'b0;
            r_cbank <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_run <= (w_next_state == S_WAIT_DONE);
            if (w_start_acc) begin
                r_cbank <= i_bank_in;
            end else if (w_next_state == S_IDLE) begin
                r_cbank <= 1'b0;
            end
            if (w_start_acc) begin
                r_err <= 1'b0;
            end else if (w_to_hit && !i_done) begin
                r_err <= 1'b1;
            end
        end
    end

    // Readback capture; the value stays put until the next RD_CAP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_res_data <= {DATA_W{1'b0}};
        end else if (r_state == S_RD_CAP) begin
            r_res_data <= i_exrd;
        end
    end

    // External port: load path is a same-cycle pass-through of the accepted word.
    always_comb begin
        o_exa = L_A_ZERO;
        case (r_state)
            S_LOAD:     o_exa = r_wr_addr;
            S_RD_ISSUE: o_exa = r_rd_addr;
            default:    o_exa = L_A_ZERO;
        endcase
    end

    assign o_exwe      = w_wr_hs;
    assign o_exwd      = w_wr_hs ? i_src_data : {DATA_W{1'b0}};
    assign o_exromul   = w_wr_hs ? i_src_romul : {ROMUL_W{1'b0}};
    assign o_exre      = (r_state == S_RD_ISSUE);
    assign o_src_ready = (r_state == S_LOAD);
    assign o_res_valid = (r_state == S_RD_HOLD);
    assign o_res_data  = r_res_data;
    assign o_busy      = (r_state != S_IDLE);
    assign o_run       = r_run;
    assign o_cbank     = r_cbank;
    assign o_err       = r_err;

endmodule
